// File: rtl/capi_put_align_pkg.sv
// Shared widths, state encoding and output-beat payload for the put-stream realigner.
package capi_put_align_pkg;

  localparam int unsigned BEAT_BYTES = 16;
  localparam int unsigned BEAT_DW    = 128;
  localparam int unsigned PAR_W      = 2;
  localparam int unsigned OFS_W      = 4;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    MID   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic                  e;
    logic [BEAT_BYTES-1:0] be;
    logic [PAR_W-1:0]      par;
    logic [BEAT_DW-1:0]    d;
  } out_beat_t;

  localparam int unsigned OUT_W = $bits(out_beat_t);

endpackage

// File: rtl/capi_put_align_cells.sv
// Small library cells: half-beat parity check/generate and an enabled register.

// Even-parity check of one 64-bit half against its parity bit.
module capi_parcheck (
  input  logic [63:0] data,
  input  logic        par,
  output logic        err_c
);
  assign err_c = (^data) ^ par;
endmodule

// Even-parity generation for one 64-bit half.
module capi_parity_gen (
  input  logic [63:0] data,
  output logic        par_c
);
  assign par_c = ^data;
endmodule

// Load-enabled register with synchronous active-high clear.
module base_alatch #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Capture d when enabled; clear on reset
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/capi_put_align_shift.sv
// Combinational byte shifter of {held beat, current beat} by s, plus byte-enable masks.
module capi_put_align_shift
  import capi_put_align_pkg::*;
(
  input  logic [BEAT_DW-1:0]    h,
  input  logic [BEAT_DW-1:0]    cur,
  input  logic [OFS_W-1:0]      s,
  input  logic [CNT_W-1:0]      t,
  input  logic                  first,
  input  logic                  last,
  input  logic                  flush,
  output logic [BEAT_DW-1:0]    d,
  output logic [BEAT_BYTES-1:0] be
);

  logic [OFS_W-1:0] src;

  // Bytes below s come from the tail of h, the rest from the head of cur; flush beats zero the upper part
  always_comb begin
    d   = '0;
    be  = '0;
    src = '0;
    for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
      src = 4'(j) - s;
      if (4'(j) < s)  d[8*j +: 8] = h[{src, 3'b000} +: 8];
      else if (!flush) d[8*j +: 8] = cur[{src, 3'b000} +: 8];

      if (flush) begin
        be[j] = 5'(j) < (t - 5'd16);
      end else begin
        be[j] = !first || (4'(j) >= s);
        if (last) be[j] = be[j] && (5'(j) < t);
      end
    end
  end

endmodule

// File: rtl/capi_put_align_plus.sv
// Write-side byte realigner: shifts a byte-0 aligned put stream to offset i_s with byte enables.
module capi_put_align_plus
  import capi_put_align_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_v,
  output logic                        i_r,
  input  logic [BEAT_DW+PAR_W-1:0]    i_d,
  input  logic [OFS_W-1:0]            i_s,
  input  logic [OFS_W-1:0]            i_c,
  input  logic                        i_e,
  output logic                        o_v,
  input  logic                        o_r,
  output logic [BEAT_DW+PAR_W-1:0]    o_d,
  output logic [BEAT_BYTES-1:0]       o_be,
  output logic                        o_e,
  output logic [PAR_W-1:0]            o_s1_perror,
  output logic                        o_perror
);

  state_e              state, state_nxt;
  logic [OFS_W-1:0]    s_q, s_cur;
  logic [CNT_W-1:0]    t_q, t_in, t_cur, c16;
  logic [BEAT_DW-1:0]  h;
  logic                slot_free, accept, first, spill, out_load, in_flush;
  logic [BEAT_DW-1:0]  sh_d;
  logic [BEAT_BYTES-1:0] sh_be;
  logic [PAR_W-1:0]    sh_par;
  logic                err_lo, err_hi;
  out_beat_t           beat_nxt, beat_q;

  // Flow control, offset/length selection and next-state decode
  always_comb begin
    state_nxt = state;
    in_flush  = (state == FLUSH);
    first     = (state == FIRST);
    slot_free = ~o_v | o_r;
    i_r       = ~in_flush & slot_free;
    accept    = i_v & i_r;
    c16       = (i_c == 4'd0) ? 5'd16 : {1'b0, i_c};
    s_cur     = first ? i_s : s_q;
    t_in      = {1'b0, s_cur} + c16;
    spill     = t_in > 5'd16;
    t_cur     = in_flush ? t_q : t_in;
    out_load  = accept | (in_flush & slot_free);
    unique case (state)
      FIRST, MID: if (accept) state_nxt = i_e ? (spill ? FLUSH : FIRST) : MID;
      FLUSH:      if (slot_free) state_nxt = FIRST;
      default:    state_nxt = FIRST;
    endcase
  end

  capi_put_align_shift u_shift (
    .h     (h),
    .cur   (i_d[BEAT_DW-1:0]),
    .s     (s_cur),
    .t     (t_cur),
    .first (first),
    .last  (i_e & ~spill),
    .flush (in_flush),
    .d     (sh_d),
    .be    (sh_be)
  );

  capi_parity_gen u_pgen_lo (.data(sh_d[63:0]),   .par_c(sh_par[0]));
  capi_parity_gen u_pgen_hi (.data(sh_d[127:64]), .par_c(sh_par[1]));

  capi_parcheck u_pchk_lo (.data(i_d[63:0]),   .par(i_d[128]), .err_c(err_lo));
  capi_parcheck u_pchk_hi (.data(i_d[127:64]), .par(i_d[129]), .err_c(err_hi));

  // Assemble the next output beat; flush beats are always the stream's last
  always_comb begin
    beat_nxt     = '0;
    beat_nxt.d   = sh_d;
    beat_nxt.par = sh_par;
    beat_nxt.be  = sh_be;
    beat_nxt.e   = in_flush ? 1'b1 : (i_e & ~spill);
  end

  base_alatch #(.W(OUT_W)) u_oreg (
    .clk   (clk),
    .reset (reset),
    .en    (out_load),
    .d     (beat_nxt),
    .q     (beat_q)
  );

  assign o_d  = {beat_q.par, beat_q.d};
  assign o_be = beat_q.be;
  assign o_e  = beat_q.e;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FIRST;
    else       state <= state_nxt;
  end

  // Hold register, latched offset/length, sticky parity and output valid
  always_ff @(posedge clk) begin
    if (reset) begin
      h           <= '0;
      s_q         <= '0;
      t_q         <= '0;
      o_s1_perror <= '0;
      o_perror    <= 1'b0;
      o_v         <= 1'b0;
    end else begin
      if (accept)         h   <= i_d[BEAT_DW-1:0];
      if (accept & first) s_q <= i_s;
      if (accept & i_e)   t_q <= t_in;
      // bit 0 flags the half guarded by i_d[129], bit 1 the half guarded by i_d[128]
      if (accept)         o_s1_perror <= o_s1_perror | {err_lo, err_hi};
      o_perror <= |o_s1_perror;
      if (out_load)       o_v <= 1'b1;
      else if (o_r)       o_v <= 1'b0;
    end
  end

endmodule
